// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode encodings and shift-count width helper for univ_shift_reg
package univ_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to hold a shift count from 0 up to and including width.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CW    = 4,
    parameter int LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with saturating shift count; UNIV_SHIFT_REG_ROTATE_EN adds rot input
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic [WIDTH-1:0]            d,
    input  logic                        sin_r,
    input  logic                        sin_l,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic                        rot,
`endif
    output logic [WIDTH-1:0]            q,
    output logic                        sout_l,
    output logic                        sout_r,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                        full
);

    localparam int CW = cnt_width(WIDTH);

    logic fill_r;
    logic fill_l;
    logic do_shift;
    logic do_load;

    // Bits entering the vacated end on a shift; rotate recirculates q instead.
    always_comb begin
        fill_r = sin_r;
        fill_l = sin_l;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        if (rot) begin
            fill_r = q[WIDTH-1];
            fill_l = q[0];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            case (mode)
                MODE_SHL:  q <= {q[WIDTH-2:0], fill_r};
                MODE_SHR:  q <= {fill_l, q[WIDTH-1:1]};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

    assign do_shift = en && ((mode == MODE_SHL) || (mode == MODE_SHR));
    assign do_load  = en && (mode == MODE_LOAD);

    sat_counter #(
        .CW    (CW),
        .LIMIT (WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (do_load),
        .inc (do_shift),
        .cnt (cnt)
    );

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign full   = (cnt == CW'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg (WIDTH=8, RST_VAL=8'hA5)
module tb_univ_shift_reg;

    localparam int         W    = 8;
    localparam logic [7:0] RSTV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    logic       rot = 1'b0;
`endif
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] cnt;
    logic       full;

    typedef struct {
        string      name;
        logic [7:0] q;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    univ_shift_reg #(
        .WIDTH   (W),
        .RST_VAL (RSTV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .cnt    (cnt),
        .full   (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %0h want %0h", n, f, act, req);
        end
    endtask

    // Monitor: every expectation pushed after an edge is checked on the next falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.name, "q", 64'(q), 64'(e.q));
            chk(e.name, "cnt", 64'(cnt), 64'(e.cnt));
            chk(e.name, "full", 64'(full), 64'(e.cnt == W));
            chk(e.name, "sout_l", 64'(sout_l), 64'(e.q[7]));
            chk(e.name, "sout_r", 64'(sout_r), 64'(e.q[0]));
        end
    end

    task automatic step(input string n, input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] dv, input logic sr, input logic sl,
                        input logic [7:0] eq, input int ec);
        exp_t x;
        @(negedge clk);
        #1;
        rst = r; en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        x.name = n; x.q = eq; x.cnt = ec;
        exp_q.push_back(x);
    endtask

    initial begin
        // reset with load requested: reset wins
        step("rst_load", 1, 1, 2'b11, 8'hFF, 0, 0, 8'hA5, 0);
        step("rst_en0", 1, 0, 2'b01, 8'h00, 1, 1, 8'hA5, 0);
        // load then shift left; sin_l must be ignored
        step("ld81", 0, 1, 2'b11, 8'h81, 0, 1, 8'h81, 0);
        step("shl1", 0, 1, 2'b01, 8'h00, 1, 1, 8'h03, 1);
        step("shl2", 0, 1, 2'b01, 8'h00, 1, 1, 8'h07, 2);
        step("shl3", 0, 1, 2'b01, 8'h00, 1, 1, 8'h0F, 3);
        // shift right past saturation; sin_r must be ignored
        step("ld80", 0, 1, 2'b11, 8'h80, 1, 0, 8'h80, 0);
        step("shr1", 0, 1, 2'b10, 8'h00, 1, 0, 8'h40, 1);
        step("shr2", 0, 1, 2'b10, 8'h00, 1, 0, 8'h20, 2);
        step("shr3", 0, 1, 2'b10, 8'h00, 1, 0, 8'h10, 3);
        step("shr4", 0, 1, 2'b10, 8'h00, 1, 0, 8'h08, 4);
        step("shr5", 0, 1, 2'b10, 8'h00, 1, 0, 8'h04, 5);
        step("shr6", 0, 1, 2'b10, 8'h00, 1, 0, 8'h02, 6);
        step("shr7", 0, 1, 2'b10, 8'h00, 1, 0, 8'h01, 7);
        step("shr8", 0, 1, 2'b10, 8'h00, 1, 0, 8'h00, 8);
        step("shr9_sat", 0, 1, 2'b10, 8'h00, 1, 0, 8'h00, 8);
        step("ld55_after_full", 0, 1, 2'b11, 8'h55, 0, 0, 8'h55, 0);
        // enable low holds, then reset mid-shift
        step("ld3c", 0, 1, 2'b11, 8'h3C, 0, 0, 8'h3C, 0);
        for (int i = 0; i < 5; i++)
            step("en0_hold", 0, 0, 2'b01, 8'h00, 1, 1, 8'h3C, 0);
        step("shl_3c", 0, 1, 2'b01, 8'h00, 1, 0, 8'h79, 1);
        step("rst_mid", 1, 1, 2'b01, 8'h00, 1, 1, 8'hA5, 0);
        // hold mode and alternating directions
        step("hold_a5", 0, 1, 2'b00, 8'h12, 1, 1, 8'hA5, 0);
        step("alt_shl", 0, 1, 2'b01, 8'h00, 0, 1, 8'h4A, 1);
        step("alt_hold", 0, 1, 2'b00, 8'h00, 1, 1, 8'h4A, 1);
        step("alt_shr", 0, 1, 2'b10, 8'h00, 0, 1, 8'hA5, 2);
        step("alt_shl2", 0, 1, 2'b01, 8'h00, 1, 0, 8'h4B, 3);
        step("en0_load", 0, 0, 2'b11, 8'h00, 0, 0, 8'h4B, 3);
        step("rst_in_load", 1, 1, 2'b11, 8'h66, 0, 0, 8'hA5, 0);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        step("rot_ld81", 0, 1, 2'b11, 8'h81, 0, 0, 8'h81, 0);
        rot = 1'b1;
        step("rot_shl", 0, 1, 2'b01, 8'h00, 0, 0, 8'h03, 1);
        step("rot_shr1", 0, 1, 2'b10, 8'h00, 0, 0, 8'h81, 2);
        step("rot_shr2", 0, 1, 2'b10, 8'h00, 0, 0, 8'hC0, 3);
        rot = 1'b0;
        step("norot_shl", 0, 1, 2'b01, 8'h00, 0, 0, 8'h80, 4);
`endif
        @(negedge clk);
        #1;
        en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  clock enable; 0 holds all state.
REQ-006 mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 d  input  WIDTH  parallel load data.
REQ-008 sin_r  input  1  serial input entering bit 0 on shift left.
REQ-009 sin_l  input  1  serial input entering bit WIDTH-1 on shift right.
REQ-010 q  output  WIDTH  register contents, registered.
REQ-011 sout_l  output  1  equals q[WIDTH-1], combinational from q.
REQ-012 sout_r  output  1  equals q[0], combinational from q.
REQ-013 cnt  output  $clog2(WIDTH+1)  shifts since last load or reset, saturating, registered.
REQ-014 full  output  1  high when cnt == WIDTH, combinational from cnt.

Function
REQ-015 Priority per edge: rst, then en, then mode.
REQ-016 en=0: q and cnt hold, regardless of mode.
REQ-017 en=1, mode=00: q and cnt hold.
REQ-018 en=1, mode=01: q <= {q[WIDTH-2:0], sin_r}; cnt increments by 1.
REQ-019 en=1, mode=10: q <= {sin_l, q[WIDTH-1:1]}; cnt increments by 1.
REQ-020 en=1, mode=11: q <= d; cnt <= 0.
REQ-021 cnt saturates at WIDTH; further shifts leave cnt == WIDTH and full == 1; it does not wrap to 0.
REQ-022 Latency: any q change is visible the cycle after the qualifying edge; sout_l, sout_r and full track q and cnt with no extra cycle.
REQ-023 Alternating left and right shifts each increment cnt; direction does not decrement it.
REQ-024 Serial inputs are sampled only on shift edges of the matching direction; the opposite serial input is ignored.

Reset
REQ-025 rst=1 at an edge: q <= RST_VAL, cnt <= 0, full = 0, independent of en and mode.
REQ-026 rst asserted mid-sequence (during shifting or load) overrides that edge completely; no partial update.
REQ-027 Before the first reset edge, outputs are undefined; the bench must not check them.

Configuration
REQ-028 Macro UNIV_SHIFT_REG_ROTATE_EN adds input rot (1 bit).
REQ-029 With the macro defined and rot=1: mode 01 takes q[WIDTH-1] into bit 0 and mode 10 takes q[0] into bit WIDTH-1 (rotate); sin_r and sin_l are ignored; cnt behaves as for shifts.
REQ-030 With the macro defined and rot=0, or with the macro undefined: behaviour is exactly REQ-018/REQ-019; the rot port does not exist when the macro is undefined.

Structure
REQ-031 Shared package univ_shift_reg_pkg holds the mode encodings (MODE_HOLD, MODE_SHL, MODE_SHR, MODE_LOAD) and the cnt-width function.
REQ-032 Single sub-module sat_counter (parametrised width and limit, with sync clear and increment) implements cnt; the q datapath stays in the top module.

Verification
REQ-033 WIDTH=8, RST_VAL=8'hA5, rst=1 for one edge with mode=11, d=8'hFF -> q=8'hA5, cnt=0, full=0.
REQ-034 Load d=8'h81, then shift left 3 edges with sin_r=1 -> q=8'h0F, cnt=3, sout_l=0, sout_r=1.
REQ-035 Load 8'h80, then shift right 9 edges with sin_l=0 -> q=8'h00 after 8 edges; cnt=8 and full=1 after edges 8 and 9.
REQ-036 en=0 with mode=01 for 5 edges after load 8'h3C -> q=8'h3C, cnt=0; then rst=1 during shifting with en=1 -> q=RST_VAL, cnt=0 on that edge.
REQ-037 Macro defined, rot=1: load 8'h81, shift left 1 edge -> q=8'h03; then shift right 2 edges -> q=8'hC0, cnt=3.
REQ-038 Load 8'h55 after full=1 -> q=8'h55, cnt=0, full=0 the next cycle.
